// File: rtl/iram_load_arbiter.sv
// ---------------------------------------------------------------------------
// iram_load_arbiter
//
// Owns the single port of the instruction RAM and shares it between the CPU
// fetch path and a byte-serial program loader. While the loader holds the
// grant, the CPU is stalled and incoming bytes (high byte first) are packed
// into 16-bit words and written sequentially from word 0.
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   CPU_ADDR / CPU_Q      CPU byte fetch address, returned instruction word
//   CPU_STALL             high while the CPU does not own the RAM
//   LD_REQ / LD_GNT       loader ownership request (level) and grant
//   LD_VALID / LD_BYTE    loader byte stream, accepted when LD_READY is high
//   LD_READY              arbiter can take a byte this cycle
//   LD_DONE               loader release pulse
//   LD_COUNT / LD_ERR     words written this session, sticky overflow flag
//   MEM_ADDR/WDATA/WE/Q   IRAM port (combinational read)
// ---------------------------------------------------------------------------
module iram_load_arbiter #(
    parameter int WORDS = 128,
    parameter int CNT_W = 8
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [$clog2(WORDS):0]     CPU_ADDR,
    output logic [15:0]                CPU_Q,
    output logic                       CPU_STALL,
    input  logic                       LD_REQ,
    output logic                       LD_GNT,
    input  logic                       LD_VALID,
    input  logic [7:0]                 LD_BYTE,
    output logic                       LD_READY,
    input  logic                       LD_DONE,
    output logic [CNT_W-1:0]           LD_COUNT,
    output logic                       LD_ERR,
    output logic [$clog2(WORDS)-1:0]   MEM_ADDR,
    output logic [15:0]                MEM_WDATA,
    output logic                       MEM_WE,
    input  logic [15:0]                MEM_Q
);

    localparam int AW = $clog2(WORDS);
    // Pointer carries one extra bit so it can sit at WORDS without wrapping.
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] WORDS_P = PW'(WORDS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        GET_HI  = 3'd2,
        GET_LO  = 3'd3,
        WRITE   = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;
    logic [7:0]         hi_q,    hi_d;
    logic [7:0]         lo_q,    lo_d;
    logic               pend_q,  pend_d;
    logic               done_eff;

    // The byte-select bit of the CPU address plays no part in a word fetch.
    logic unused_addr_lsb;
    assign unused_addr_lsb = CPU_ADDR[0];

    assign LD_COUNT = cnt_q;
    assign LD_ERR   = err_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;

        CPU_Q     = '0;
        CPU_STALL = 1'b1;
        LD_GNT    = 1'b0;
        LD_READY  = 1'b0;
        MEM_ADDR  = ptr_q[AW-1:0];
        MEM_WDATA = '0;
        MEM_WE    = 1'b0;

        // Dropping LD_REQ while granted counts as a release request.
        done_eff  = LD_DONE | ~LD_REQ;

        unique case (state_q)
            IDLE: begin
                MEM_ADDR  = CPU_ADDR[AW:1];
                CPU_Q     = MEM_Q;
                CPU_STALL = 1'b0;
                if (LD_REQ) state_d = DRAIN;
            end

            DRAIN: begin
                ptr_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                pend_d  = 1'b0;
                state_d = GET_HI;
            end

            GET_HI: begin
                LD_GNT   = 1'b1;
                LD_READY = 1'b1;
                if (LD_VALID) begin
                    hi_d    = LD_BYTE;
                    if (done_eff) pend_d = 1'b1;
                    state_d = GET_LO;
                end else if (done_eff) begin
                    state_d = RELEASE;
                end
            end

            GET_LO: begin
                LD_GNT   = 1'b1;
                LD_READY = 1'b1;
                if (LD_VALID) begin
                    lo_d    = LD_BYTE;
                    if (done_eff) pend_d = 1'b1;
                    state_d = WRITE;
                end else if ((LD_DONE && !pend_q) || !LD_REQ) begin
                    // A half word is dropped silently; a repeated DONE while
                    // one is already pending just keeps waiting for the byte.
                    pend_d  = 1'b0;
                    state_d = RELEASE;
                end
            end

            WRITE: begin
                LD_GNT    = 1'b1;
                MEM_WDATA = {hi_q, lo_q};
                if (ptr_q < WORDS_P) begin
                    MEM_WE = 1'b1;
                    ptr_d  = ptr_q + PW'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    err_d  = 1'b1;
                end
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = RELEASE;
                end else begin
                    state_d = GET_HI;
                end
            end

            RELEASE: begin
                // No re-grant until the loader has dropped its request.
                if (!LD_REQ) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_iram_load_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for iram_load_arbiter. Expected IRAM writes are queued as the
// stimulus is issued; a monitor pops and compares on every MEM_WE strobe.
// ---------------------------------------------------------------------------
module tb_iram_load_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  CPU_ADDR;
    logic [15:0] CPU_Q;
    logic        CPU_STALL;
    logic        LD_REQ;
    logic        LD_GNT;
    logic        LD_VALID;
    logic [7:0]  LD_BYTE;
    logic        LD_READY;
    logic        LD_DONE;
    logic [7:0]  LD_COUNT;
    logic        LD_ERR;
    logic [6:0]  MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic        MEM_WE;
    logic [15:0] MEM_Q;

    always #5 CLK = ~CLK;

    iram_load_arbiter #(.WORDS(128), .CNT_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CPU_ADDR(CPU_ADDR), .CPU_Q(CPU_Q), .CPU_STALL(CPU_STALL),
        .LD_REQ(LD_REQ), .LD_GNT(LD_GNT), .LD_VALID(LD_VALID),
        .LD_BYTE(LD_BYTE), .LD_READY(LD_READY), .LD_DONE(LD_DONE),
        .LD_COUNT(LD_COUNT), .LD_ERR(LD_ERR),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
        .MEM_Q(MEM_Q)
    );

    // IRAM model with an override used for the passthrough vector.
    logic [15:0] mem [128];
    logic        use_ovr;
    logic [15:0] ovr_q;
    assign MEM_Q = use_ovr ? ovr_q : mem[MEM_ADDR];
    always @(posedge CLK) if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;

    typedef struct packed {
        logic [6:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t sb[$];

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Write monitor
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && MEM_WE === 1'b1) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                         MEM_ADDR, MEM_WDATA);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(MEM_ADDR), 32'(e.a));
                check("wr_data", 32'(MEM_WDATA), 32'(e.d));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!LD_READY && n < 50) begin
            step();
            n++;
        end
        if (!LD_READY) check("ready_timeout", 32'(LD_READY), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        wait_ready();
        LD_VALID = 1'b1;
        LD_BYTE  = b;
        LD_DONE  = done;
        step();
        LD_VALID = 1'b0;
        LD_DONE  = 1'b0;
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        RESET_N  = 1'b0;
        CPU_ADDR = '0;
        LD_REQ   = 1'b0;
        LD_VALID = 1'b0;
        LD_BYTE  = '0;
        LD_DONE  = 1'b0;
        use_ovr  = 1'b0;
        ovr_q    = '0;
        #12;
        check("rst_stall",  32'(CPU_STALL), 0);
        check("rst_gnt",    32'(LD_GNT), 0);
        check("rst_ready",  32'(LD_READY), 0);
        check("rst_we",     32'(MEM_WE), 0);
        check("rst_wdata",  32'(MEM_WDATA), 0);
        check("rst_count",  32'(LD_COUNT), 0);
        check("rst_err",    32'(LD_ERR), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        step();

        // Idle passthrough
        use_ovr  = 1'b1;
        ovr_q    = 16'h5EFF;
        CPU_ADDR = 8'h0E;
        #1;
        check("idle_addr",  32'(MEM_ADDR), 7);
        check("idle_q",     32'(CPU_Q), 32'h5EFF);
        check("idle_stall", 32'(CPU_STALL), 0);
        use_ovr = 1'b0;
        step();

        // Basic load: two words then release
        LD_REQ = 1'b1;
        step();
        check("drain_stall", 32'(CPU_STALL), 1);
        check("drain_gnt",   32'(LD_GNT), 0);
        check("drain_cpuq",  32'(CPU_Q), 0);
        step();
        check("gnt_latency", 32'(LD_GNT), 1);
        push_wr(7'd0, 16'hF001);
        push_wr(7'd1, 16'hF291);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hF2, 1'b0);
        send_byte(8'h91, 1'b0);
        wait_ready();
        LD_DONE = 1'b1;
        LD_REQ  = 1'b0;
        step();
        LD_DONE = 1'b0;
        check("rel_gnt",   32'(LD_GNT), 0);
        check("rel_stall", 32'(CPU_STALL), 1);
        step();
        check("resume_stall", 32'(CPU_STALL), 0);
        check("basic_count",  32'(LD_COUNT), 2);
        CPU_ADDR = 8'h02;
        #1;
        check("readback_w1", 32'(CPU_Q), 32'hF291);
        CPU_ADDR = 8'h01;
        #1;
        check("readback_w0", 32'(CPU_Q), 32'hF001);
        step();

        // Partial word discarded
        LD_REQ = 1'b1;
        step();
        step();
        send_byte(8'hAB, 1'b0);
        LD_DONE = 1'b1;
        LD_REQ  = 1'b0;
        step();
        LD_DONE = 1'b0;
        step();
        check("part_stall", 32'(CPU_STALL), 0);
        check("part_count", 32'(LD_COUNT), 0);
        check("part_err",   32'(LD_ERR), 0);
        check("part_gnt",   32'(LD_GNT), 0);

        // Same-cycle VALID+DONE on the low byte
        LD_REQ = 1'b1;
        step();
        step();
        push_wr(7'd0, 16'h1234);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        step();
        check("sc_rel_gnt",   32'(LD_GNT), 0);
        check("sc_rel_ready", 32'(LD_READY), 0);
        check("sc_rel_stall", 32'(CPU_STALL), 1);
        step();
        check("sc_hold_gnt",  32'(LD_GNT), 0);
        check("sc_hold_stall", 32'(CPU_STALL), 1);
        LD_REQ = 1'b0;
        step();
        check("sc_idle_stall", 32'(CPU_STALL), 0);
        check("sc_count",      32'(LD_COUNT), 1);

        // Overflow: 129 words, last one rejected
        LD_REQ = 1'b1;
        step();
        step();
        for (int i = 0; i < 129; i++) begin
            b = 8'(i);
            if (i < 128) push_wr(7'(i), {b, ~b});
            send_byte(b, 1'b0);
            send_byte(~b, 1'b0);
        end
        check("ovf_no_we",   32'(MEM_WE), 0);
        check("ovf_count",   32'(LD_COUNT), 128);
        wait_ready();
        check("ovf_err",     32'(LD_ERR), 1);
        LD_DONE = 1'b1;
        LD_REQ  = 1'b0;
        step();
        LD_DONE = 1'b0;
        step();
        check("ovf_idle_stall", 32'(CPU_STALL), 0);
        check("ovf_err_hold",   32'(LD_ERR), 1);
        check("ovf_cnt_hold",   32'(LD_COUNT), 128);
        LD_REQ = 1'b1;
        step();
        step();
        check("new_err_clr", 32'(LD_ERR), 0);
        check("new_cnt_clr", 32'(LD_COUNT), 0);

        // Async reset in GET_LO
        send_byte(8'h55, 1'b0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_we",    32'(MEM_WE), 0);
        check("arst_gnt",   32'(LD_GNT), 0);
        check("arst_stall", 32'(CPU_STALL), 0);
        check("arst_ready", 32'(LD_READY), 0);
        LD_REQ = 1'b0;
        #2;
        RESET_N = 1'b1;
        step();
        check("post_rst_stall", 32'(CPU_STALL), 0);
        check("post_rst_gnt",   32'(LD_GNT), 0);
        check("post_rst_count", 32'(LD_COUNT), 0);
        step();
        check("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/iram_load_arbiter.md
Name: iram_load_arbiter

Overview:
- Owns the single port of the 128 x 16-bit instruction RAM and shares it between two requesters: the CPU fetch path (byte address in, 16-bit word out) and a byte-serial program loader.
- While the loader holds the grant, the CPU is stalled and the loader streams bytes that are packed into words and written sequentially from word 0.
- Sits between the core's fetch stage, the IRAM array and the board-level debug/load port.

Parameters:
- WORDS, 128, number of 16-bit IRAM words; word address width = clog2(WORDS) = 7.
- CNT_W, 8, width of LD_COUNT; must satisfy 2^CNT_W > WORDS.

Ports:
- CLK, in, 1, system clock; all state updates on rising edge.
- RESET_N, in, 1, asynchronous active-low reset.
- CPU_ADDR, in, 8, CPU byte fetch address; word address = CPU_ADDR[7:1].
- CPU_Q, out, 16, instruction word returned to the CPU.
- CPU_STALL, out, 1, high while the CPU does not own the RAM.
- LD_REQ, in, 1, loader requests ownership (level).
- LD_GNT, out, 1, loader owns the RAM.
- LD_VALID, in, 1, LD_BYTE valid this cycle.
- LD_BYTE, in, 8, load data byte; high byte of each word first.
- LD_READY, out, 1, arbiter accepts a byte when LD_VALID & LD_READY.
- LD_DONE, in, 1, loader releases ownership (pulse).
- LD_COUNT, out, CNT_W, words written in the current/last load session.
- LD_ERR, out, 1, sticky: write attempted past word WORDS-1.
- MEM_ADDR, out, 7, word address to IRAM.
- MEM_WDATA, out, 16, write data to IRAM.
- MEM_WE, out, 1, IRAM write strobe (one cycle per word).
- MEM_Q, in, 16, IRAM read data (combinational read).

Behaviour:
- Reset (async, immediate):
  - State = IDLE, CPU_STALL = 0, LD_GNT = 0, LD_READY = 0, MEM_WE = 0.
  - MEM_WDATA = 0, LD_COUNT = 0, LD_ERR = 0, write pointer = 0, hi-byte register = 0.
  - Reset asserted mid-load abandons any partial word; no write is issued.
- States:
  - IDLE:
    - MEM_ADDR = CPU_ADDR[7:1]; CPU_Q = MEM_Q; CPU_STALL = 0.
    - LD_REQ = 1 -> DRAIN.
  - DRAIN (1 cycle):
    - CPU_STALL = 1, CPU_Q = 16'h0000.
    - Clears the write pointer, LD_COUNT and LD_ERR.
    - -> GET_HI.
  - GET_HI:
    - LD_GNT = 1, LD_READY = 1.
    - On a handshake: latch LD_BYTE into bits [15:8] -> GET_LO.
    - LD_DONE without LD_VALID -> RELEASE.
  - GET_LO:
    - LD_READY = 1.
    - On a handshake: form {hi, LD_BYTE} -> WRITE.
    - LD_DONE without LD_VALID: discard the partial word, no error -> RELEASE.
  - WRITE (1 cycle):
    - LD_READY = 0; MEM_ADDR = pointer; MEM_WDATA = word.
    - MEM_WE = 1 only if pointer < WORDS; pointer and LD_COUNT +1 in that case.
    - Otherwise MEM_WE = 0, LD_ERR <= 1, pointer holds.
    - Pending-done set -> RELEASE, else -> GET_HI.
  - RELEASE (1 cycle):
    - LD_GNT = 0, CPU_STALL = 1.
    - -> IDLE when LD_REQ = 0; otherwise wait here (no re-grant until LD_REQ drops).
- CPU_STALL = 1 in every state except IDLE; CPU_Q = 16'h0000 whenever CPU_STALL = 1 (the zero word is the RAM fill pattern).
- Outside WRITE, MEM_WE = 0 and MEM_WDATA = 0.
- Simultaneous events:
  - LD_VALID & LD_DONE in the same cycle: the byte is accepted and pending-done is set. The word completes (GET_LO) and is written, then -> RELEASE. If this happens in GET_HI, the remaining low byte must still arrive before release; pending-done stays set until it does.
  - LD_REQ dropping while granted (before LD_DONE) is treated as LD_DONE in that cycle.
- Latency:
  - LD_REQ rise to LD_GNT: 2 cycles.
  - Word write: 1 cycle after the low-byte handshake.
  - LD_DONE to CPU resume: 2 cycles (RELEASE, then IDLE) when LD_REQ is already low.
- LD_COUNT and LD_ERR hold their values after release until the next DRAIN.
- Write pointer wrap is not permitted: it saturates at WORDS and flags LD_ERR.

Test Plan:
- Idle passthrough: no LD_REQ; CPU_ADDR = 8'h0E with MEM_Q = 16'h5EFF -> MEM_ADDR = 7, CPU_Q = 16'h5EFF, CPU_STALL = 0.
- Basic load: LD_REQ, then bytes F0,01,F2,91 each with a handshake, then LD_DONE -> MEM_WE pulses at addr 0 data 16'hF001 and addr 1 data 16'hF291, LD_COUNT = 2, LD_GNT falls, CPU_STALL = 0 two cycles after LD_DONE once LD_REQ = 0.
- Partial word: bytes AB then LD_DONE alone in GET_LO -> no MEM_WE, LD_COUNT = 0, LD_ERR = 0, return to IDLE.
- Overflow: stream 129 words -> 128 writes (addr 0..127), 129th gives MEM_WE = 0, LD_ERR = 1, LD_COUNT = 128; a new LD_REQ session clears LD_ERR in DRAIN.
- Same-cycle VALID+DONE on low byte 8'h34 after hi 8'h12 -> write 16'h1234, then RELEASE with no further GET_HI.
- Async reset: assert RESET_N = 0 in GET_LO -> MEM_WE = 0, LD_GNT = 0, CPU_STALL = 0 immediately without a clock edge; after release, state is IDLE.
